fetch_stage_p: RTL



---
 rtl/fetch_stage_p_if.sv | 31 +++
 rtl/fetch_stage_p.sv | 89 ++++++++
 2 files changed

// File: rtl/fetch_stage_p_if.sv
// Fetch-stage bus: redirect controls, instruction-memory port and the
// fetch/decode pipeline register outputs bundled as one interface.
interface fetch_stage_p_if #(
    parameter int PC_WIDTH     = 20,
    parameter int INSTR_WIDTH  = 16,
    parameter int OFFSET_WIDTH = 9,
    parameter int COUNT_WIDTH  = 32
);
    logic                    stall;
    logic [1:0]              pcjumpenable;
    logic [OFFSET_WIDTH-1:0] pcchange;
    logic [PC_WIDTH-1:0]     pclocation;
    logic [PC_WIDTH-1:0]     instruction_rd1;
    logic [INSTR_WIDTH-1:0]  instruction_rd1_out;
    logic [INSTR_WIDTH-1:0]  fetchoutput;
    logic                    fetch_valid;
    logic [PC_WIDTH-1:0]     previous_programcounter;
    logic [COUNT_WIDTH-1:0]  fetch_count;

    // Driver side: decode/control and instruction memory
    modport master (
        output stall, pcjumpenable, pcchange, pclocation, instruction_rd1_out,
        input  instruction_rd1, fetchoutput, fetch_valid, previous_programcounter, fetch_count
    );

    // Fetch stage side
    modport slave (
        input  stall, pcjumpenable, pcchange, pclocation, instruction_rd1_out,
        output instruction_rd1, fetchoutput, fetch_valid, previous_programcounter, fetch_count
    );
endinterface

// File: rtl/fetch_stage_p.sv
// Parametrised instruction-fetch stage: program counter, combinational
// instruction-memory address, and the fetch/decode pipeline register with
// stall, redirect bubble, relative/absolute branch and a fetch counter.
module fetch_stage_p #(
    parameter int                    PC_WIDTH     = 20,
    parameter int                    INSTR_WIDTH  = 16,
    parameter int                    OFFSET_WIDTH = 9,
    parameter logic [PC_WIDTH-1:0]   RESET_PC     = '0,
    parameter int                    COUNT_WIDTH  = 32
) (
    input  logic           clock,
    input  logic           reset,
    fetch_stage_p_if.slave bus
);
    localparam logic [1:0] MODE_RELATIVE = 2'd1;
    localparam logic [1:0] MODE_ABSOLUTE = 2'd2;

    logic [PC_WIDTH-1:0]    pc_r;
    logic [INSTR_WIDTH-1:0] fetch_word_r;
    logic                   fetch_valid_r;
    logic [PC_WIDTH-1:0]    prev_pc_r;
    logic [COUNT_WIDTH-1:0] count_r;

    logic [PC_WIDTH-1:0]    pc_next_s;
    logic [INSTR_WIDTH-1:0] fetch_word_next_s;
    logic                   fetch_valid_next_s;
    logic [PC_WIDTH-1:0]    prev_pc_next_s;
    logic [COUNT_WIDTH-1:0] count_next_s;
    logic [PC_WIDTH-1:0]    offset_ext_s;

    // Relative branches are taken from the PC of the word sitting in the
    // fetch register, so the offset is sign-extended to the PC width and the
    // sum wraps modulo 2^PC_WIDTH.
    assign offset_ext_s = PC_WIDTH'($signed(bus.pcchange));

    // Next-state selection: redirect overrides stall, stall overrides sequential fetch
    always_comb begin
        pc_next_s          = pc_r;
        fetch_word_next_s  = fetch_word_r;
        fetch_valid_next_s = fetch_valid_r;
        prev_pc_next_s     = prev_pc_r;
        count_next_s       = count_r;
        case (bus.pcjumpenable)
            MODE_RELATIVE: begin
                pc_next_s          = prev_pc_r + offset_ext_s;
                fetch_valid_next_s = 1'b0;
            end
            MODE_ABSOLUTE: begin
                pc_next_s          = bus.pclocation;
                fetch_valid_next_s = 1'b0;
            end
            default: begin
                // Modes 0 and 3 both fetch sequentially
                if (!bus.stall) begin
                    fetch_word_next_s  = bus.instruction_rd1_out;
                    prev_pc_next_s     = pc_r;
                    fetch_valid_next_s = 1'b1;
                    pc_next_s          = pc_r + {{(PC_WIDTH-1){1'b0}}, 1'b1};
                    count_next_s       = count_r + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
                end else begin
                    fetch_valid_next_s = fetch_valid_r;
                end
            end
        endcase
    end

    // PC and fetch/decode pipeline register, asynchronously reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_r          <= RESET_PC;
            fetch_word_r  <= '0;
            fetch_valid_r <= 1'b0;
            prev_pc_r     <= '0;
            count_r       <= '0;
        end else begin
            pc_r          <= pc_next_s;
            fetch_word_r  <= fetch_word_next_s;
            fetch_valid_r <= fetch_valid_next_s;
            prev_pc_r     <= prev_pc_next_s;
            count_r       <= count_next_s;
        end
    end

    assign bus.instruction_rd1         = pc_r;
    assign bus.fetchoutput             = fetch_word_r;
    assign bus.fetch_valid             = fetch_valid_r;
    assign bus.previous_programcounter = prev_pc_r;
    assign bus.fetch_count             = count_r;
endmodule
